// File: rtl/dp_ops_pkg.sv
// ============================================================================
// Module : dp_ops_pkg
// Brief  : Datapath opcodes, register map and sequencer states for dot products
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dp_ops_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        COPY  = 3'd1,
        LOAD1 = 3'd2,
        LOAD2 = 3'd3,
        ADD   = 3'd4,
        SUB   = 3'd5,
        MUL   = 3'd6
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_MUL   = 3'd2,
        S_ADD   = 3'd3,
        S_DONE  = 3'd4,
        S_EIDLE = 3'd5
    } state_t;

    localparam logic [3:0] REG_NONE    = 4'd0;
    localparam logic [3:0] SAMPLE_BASE = 4'd1;
    localparam logic [3:0] ACC         = 4'd5;
    localparam logic [3:0] TMP         = 4'd6;
    localparam logic [3:0] COEFF0_BASE = 4'd7;
    localparam logic [3:0] COEFF1_BASE = 4'd11;

    function automatic logic [3:0] coeff_reg(input logic row, input logic [2:0] k);
        return (row ? COEFF1_BASE : COEFF0_BASE) + {1'b0, k};
    endfunction

    function automatic logic [3:0] sample_reg(input logic [2:0] k);
        return SAMPLE_BASE + {1'b0, k};
    endfunction

endpackage

`default_nettype wire

// File: rtl/dot_product_sequencer_tap_counter.sv
// ============================================================================
// Module : tap_counter
// Brief  : Tap index counter with clear, enable and terminal count
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tap_counter #(
    parameter int NUM_TAPS = 4
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       i_clear,
    input  logic       i_en,
    output logic [2:0] o_k,
    output logic       o_tc
);

    localparam logic [2:0] C_LAST = 3'(NUM_TAPS - 1);

    logic [2:0] r_k;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_k <= 3'd0;
        end else if (i_clear) begin
            r_k <= 3'd0;
        end else if (i_en) begin
            r_k <= r_k + 3'd1;
        end
    end

    assign o_k  = r_k;
    assign o_tc = (r_k == C_LAST);

endmodule

`default_nettype wire

// File: rtl/dot_product_sequencer.sv
// ============================================================================
// Module : dot_product_sequencer
// Brief  : Drives the shared RF/ALU datapath to compute one dot product per start
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dot_product_sequencer
    import dp_ops_pkg::*;
#(
    parameter int NUM_TAPS = 4
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       start,
    input  logic       row_select,
    input  logic       overflow,
    output logic       modwait,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       clear,
    output logic       cnt_up,
    output logic       done,
    output logic       err
);

    state_t     r_state;
    state_t     w_next;
    logic       r_row;
    logic       r_modwait;
    logic [2:0] w_k;
    logic       w_tc;
    logic       w_cnt_clear;
    logic       w_cnt_en;
    logic       w_accept;
    op_t        w_op;
    logic [3:0] w_src1;
    logic [3:0] w_src2;
    logic [3:0] w_dest;
    logic       w_clear;
    logic       w_cnt_up;
    logic       w_done;
    logic       w_err;

    tap_counter #(
        .NUM_TAPS (NUM_TAPS)
    ) u_tap_counter (
        .clk     (clk),
        .n_reset (n_reset),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_k     (w_k),
        .o_tc    (w_tc)
    );

    // A new job may only be accepted from the three quiescent states
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                (r_state == S_EIDLE));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= S_IDLE;
            r_row     <= 1'b0;
            r_modwait <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_modwait <= (w_next == S_CLR) || (w_next == S_MUL) || (w_next == S_ADD);
            if (w_accept) begin
                r_row <= row_select;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_op        = NOP;
        w_src1      = REG_NONE;
        w_src2      = REG_NONE;
        w_dest      = REG_NONE;
        w_clear     = 1'b0;
        w_cnt_up    = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_en    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next      = S_CLR;
                    w_cnt_clear = 1'b1;
                end
            end
            S_CLR: begin
                // acc - acc zeroes the accumulator without a dedicated op
                w_op    = SUB;
                w_dest  = ACC;
                w_src1  = ACC;
                w_src2  = ACC;
                w_clear = 1'b1;
                w_next  = S_MUL;
            end
            S_MUL: begin
                w_op   = MUL;
                w_dest = TMP;
                w_src1 = sample_reg(w_k);
                w_src2 = coeff_reg(r_row, w_k);
                w_next = overflow ? S_EIDLE : S_ADD;
            end
            S_ADD: begin
                w_op   = ADD;
                w_dest = ACC;
                w_src1 = ACC;
                w_src2 = TMP;
                if (overflow) begin
                    w_next = S_EIDLE;
                end else if (w_tc) begin
                    w_next = S_DONE;
                end else begin
                    w_cnt_en = 1'b1;
                    w_next   = S_MUL;
                end
            end
            S_DONE: begin
                w_done   = 1'b1;
                w_cnt_up = 1'b1;
                if (start) begin
                    w_next      = S_CLR;
                    w_cnt_clear = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_EIDLE: begin
                w_err = 1'b1;
                if (start) begin
                    w_next      = S_CLR;
                    w_cnt_clear = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign modwait = r_modwait;
    assign op      = w_op;
    assign src1    = w_src1;
    assign src2    = w_src2;
    assign dest    = w_dest;
    assign clear   = w_clear;
    assign cnt_up  = w_cnt_up;
    assign done    = w_done;
    assign err     = w_err;

endmodule

`default_nettype wire

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
Sequences the shared register-file/ALU datapath (op/src1/src2/dest interface) to compute one dot product per request: acc = sum over k of sample[k] * coeff[row][k].
Sits between the host handshake logic and the datapath, and owns the datapath while busy.
Supports two coefficient rows, selected per request, and reports datapath overflow as a sticky error.

Parameters:
NUM_TAPS, 4, taps per dot product; legal range 1..4.

Ports:
clk  in  1  system clock, rising edge
n_reset  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE, DONE, EIDLE
row_select  in  1  coefficient row for this request; latched when start is accepted
overflow  in  1  datapath ALU overflow; combinational, valid in the same cycle as the issued op
modwait  out  1  registered busy flag
op  out  3  datapath opcode
src1  out  4  datapath source register 1
src2  out  4  datapath source register 2
dest  out  4  datapath destination register
clear  out  1  one-cycle clear pulse to the result counter, at job start
cnt_up  out  1  one-cycle pulse on successful completion
done  out  1  one-cycle pulse on successful completion, same cycle as cnt_up
err  out  1  high while in EIDLE

Behaviour:
- Register map (all from package):
  - samples k at reg 1+k
  - row0 coeff k at reg 7+k; row1 coeff k at reg 11+k
  - acc = reg 5; tmp = reg 6; reg 0 = default/no-target
- Default outputs in every state: op=NOP, src1=src2=dest=0, clear=cnt_up=done=0.
- States: IDLE, CLR, MUL, ADD, DONE, EIDLE. Tap counter k is 0..NUM_TAPS-1.
- IDLE:
  - start=1 -> CLR; latch row_select; k=0.
- CLR:
  - op=SUB, dest=5, src1=5, src2=5 (zeroes acc); clear=1.
  - -> MUL.
- MUL:
  - op=MUL, dest=6, src1=1+k, src2=(row ? 11 : 7)+k.
  - overflow=1 -> EIDLE; else -> ADD.
- ADD:
  - op=ADD, dest=5, src1=5, src2=6.
  - overflow=1 -> EIDLE.
  - else if k==NUM_TAPS-1 -> DONE.
  - else k<=k+1, -> MUL.
- DONE:
  - done=1, cnt_up=1.
  - start=1 -> CLR (back-to-back; new row latched); else -> IDLE.
- EIDLE:
  - err=1.
  - start=1 -> CLR (err drops the next cycle); else stay.
- modwait:
  - Registered, computed from next_state.
  - Asserted whenever the next state is CLR, MUL or ADD.
  - Deasserted for IDLE, DONE and EIDLE.
- Latency: start sampled at edge 0 gives CLR in cycle 1, MUL/ADD pairs in cycles 2..2*NUM_TAPS+1, and DONE in cycle 2*NUM_TAPS+2 (cycle 10 for NUM_TAPS=4).
- start is ignored in CLR, MUL and ADD.
- row_select changes after acceptance have no effect on the running job.
- overflow is ignored in all states except MUL and ADD.
- Reset, asynchronous and including mid-operation:
  - state=IDLE, k=0, latched row=0, modwait=0.
  - All outputs take their default values immediately.
  - No partial done, cnt_up or err is produced.

Decomposition:
- Package dp_ops_pkg holds:
  - op_t enum: NOP=0, COPY=1, LOAD1=2, LOAD2=3, ADD=4, SUB=5, MUL=6.
  - Register index constants: SAMPLE_BASE=1, ACC=5, TMP=6, COEFF0_BASE=7, COEFF1_BASE=11.
  - The sequencer state enum.
- One sub-module, tap_counter:
  - 3-bit counter with clear, enable and terminal-count output (k==NUM_TAPS-1).
  - Same clock and reset as the parent.

Test Plan:
- Reset, then idle: all outputs 0 and op=NOP. Reset released with start=0 for 5 cycles gives no change.
- start=1 with row_select=0, NUM_TAPS=4, overflow=0:
  - Cycle 1: CLR with op=SUB, dest/src1/src2=5, clear=1.
  - Cycle 2: MUL with src1=1, src2=7, dest=6.
  - Cycle 3: ADD with dest=5, src1=5, src2=6.
  - Cycle 8: MUL with src1=4, src2=10.
  - Cycle 10: done=cnt_up=1, modwait=0.
  - modwait=1 in cycles 1..9.
- row_select=1 with row_select toggled mid-job: every MUL uses src2=11..14 in order.
- overflow=1 during the second MUL (cycle 4):
  - Cycle 5 is EIDLE with err=1, modwait=0 and no done.
  - A later start gives CLR next cycle with err=0.
- Back-to-back: start held high through DONE gives CLR immediately after DONE. Two done pulses are exactly 10 cycles apart.
- n_reset asserted in cycle 5 of a job: outputs default immediately, modwait=0. After release, start completes a full job normally.
